// File: rtl/id_ex_hazard_ctrl.sv
// Hazard sequencer beside ID/EX: load-use stalls, taken-branch flushes, mem_busy freeze; outputs are zero-latency Mealy decode.
// Optional HAZARD_STATS_EN adds a saturating 16-bit stall_cycles counter of cycles with PC_write=0.
module id_ex_hazard_ctrl #(
  parameter int unsigned LOAD_DELAY   = 1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IDEX_MemRead,
  input  logic [4:0] IDEX_Rt_addr,
  input  logic [4:0] IFID_Rs_addr,
  input  logic [4:0] IFID_Rt_addr,
  input  logic       IFID_uses_Rt,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       PC_write,
  output logic       IFID_write,
  output logic       IFID_flush,
  output logic       IDEX_bubble,
  output logic       pipe_hold,
  output logic [1:0] state_out
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [2:0] LD_RELOAD = 3'(LOAD_DELAY - 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_cnt;
  logic [2:0] w_next_cnt;
  logic       w_h;

  assign w_h = IDEX_MemRead && (IDEX_Rt_addr != 5'd0) &&
               ((IDEX_Rt_addr == IFID_Rs_addr) ||
                (IFID_uses_Rt && (IDEX_Rt_addr == IFID_Rt_addr)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_bubble  = 1'b0;
    pipe_hold    = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;

    if (rst) begin
      PC_write     = 1'b0;
      IFID_write   = 1'b0;
      IFID_flush   = 1'b1;
      IDEX_bubble  = 1'b1;
      w_next_state = RUN;
      w_next_cnt   = 3'd0;
    end else if (mem_busy) begin
      // Freeze never consumes cnt; a freeze from RUN parks in MEM_WAIT.
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      pipe_hold  = 1'b1;
      if (r_state == RUN) w_next_state = MEM_WAIT;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          w_next_state = RUN;
          if (branch_taken) begin
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_next_state = FLUSH;
              w_next_cnt   = FL_RELOAD;
            end
          end else if (w_h) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
            if (LOAD_DELAY > 1) begin
              w_next_state = LU_STALL;
              w_next_cnt   = LD_RELOAD;
            end
          end
        end
        LU_STALL: begin
          PC_write    = 1'b0;
          IFID_write  = 1'b0;
          IDEX_bubble = 1'b1;
          w_next_cnt  = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_next_state = RUN;
        end
        FLUSH: begin
          IFID_flush  = 1'b1;
          IDEX_bubble = 1'b1;
          w_next_cnt  = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_next_state = RUN;
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  assign state_out = r_state;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 16'd0;
    end else if (!PC_write && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
